xps2_rx_fifo: RTL and testbench

XPS2_RX_FIFO -- requirements
Module: xps2_rx_fifo

---
 rtl/xps2_rx_fifo_pkg.sv | 30 +++
 rtl/xfifo_sync.sv | 67 ++++++
 rtl/xps2_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_xps2_rx_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xps2_rx_fifo_pkg.sv
// Shared PS/2 receive definitions: prefix codes, frame FSM states and
// the FIFO entry layout, also used by the keyboard decoder.
package xps2_rx_fifo_pkg;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } rx_entry_t;

  function automatic logic frame_ok(
    input logic [7:0] d,
    input logic       par,
    input logic       stop
  );
    return (^{d, par}) & stop;
  endfunction

endpackage

// File: rtl/xfifo_sync.sv
// Single-clock show-ahead FIFO with level count and sticky overflow.
// A push into a full FIFO is accepted only when a pop happens alongside it.
module xfifo_sync #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              full, do_pop, do_push;

  assign full    = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign do_pop  = rd_en_i & ~empty_o;
  assign do_push = wr_en_i & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (wr_en_i & ~do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push & ~do_pop) level_d = level_q + (ADDR_W+1)'(1);
    if (do_pop & ~do_push) level_d = level_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Storage is not reset, so the head is masked while empty.
  assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/xps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, frame FSM with timeout,
// F0/E0 prefix folding, and a show-ahead scan code FIFO.
module xps2_rx_fifo
  import xps2_rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH_W  = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_CYC   = 50000,
  parameter int FILTER_PREFIX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  rd_en,
  output logic [7:0]            data_out,
  output logic                  brk_out,
  output logic                  ext_out,
  output logic                  empty,
  output logic [FIFO_DEPTH_W:0] level,
  output logic                  overflow,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   sample, bit_in;

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic        err_q, err_d;
  logic        push, timeout;
  logic        is_brk, is_ext;
  rx_entry_t   push_entry, head;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sample  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in  = dat_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != ST_IDLE) & ~sample & (tmo_q == TMO_LAST);
  assign is_brk  = (FILTER_PREFIX != 0) && (shift_q == PS2_BRK);
  assign is_ext  = (FILTER_PREFIX != 0) && (shift_q == PS2_EXT);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    err_d      = 1'b0;
    push       = 1'b0;
    push_entry = '{ext: ext_q, brk: brk_q, code: shift_q};
    tmo_d      = (state_q == ST_IDLE || sample) ? '0 : tmo_q + TW'(1);
    if (FILTER_PREFIX == 0) push_entry = '{ext: 1'b0, brk: 1'b0, code: shift_q};
    unique case (state_q)
      ST_IDLE: begin
        if (sample && !bit_in) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d = ST_IDLE;
          if (frame_ok(shift_q, par_q, bit_in)) begin
            unique case (1'b1)
              is_brk: brk_d = 1'b1;
              is_ext: ext_d = 1'b1;
              default: begin
                push  = 1'b1;
                brk_d = 1'b0;
                ext_d = 1'b0;
              end
            endcase
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled frame is abandoned along with any pending prefix.
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      err_q     <= err_d;
    end
  end

  xfifo_sync #(
    .DATA_W (ENTRY_W),
    .ADDR_W (FIFO_DEPTH_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (push),
    .wr_data_i  (push_entry),
    .rd_en_i    (rd_en),
    .rd_data_o  (head),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign data_out = head.code;
  assign brk_out  = head.brk;
  assign ext_out  = head.ext;
  assign err      = err_q;

endmodule

// File: tb/tb_xps2_rx_fifo.sv
// Directed plus randomized bench for xps2_rx_fifo: two instances (prefix
// folding and raw mode) share one PS/2 line and are checked against queues.
module tb_xps2_rx_fifo;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int TMO   = 300;
  localparam int H     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en = 1'b0;

  logic [7:0] data_a, data_b;
  logic brk_a, ext_a, empty_a, ovf_a, err_a;
  logic brk_b, ext_b, empty_b, ovf_b, err_b;
  logic [DW:0] lvl_a, lvl_b;

  always #5 clk = ~clk;

  xps2_rx_fifo #(.FIFO_DEPTH_W(DW), .SYNC_STAGES(SYNC),
                 .TIMEOUT_CYC(TMO), .FILTER_PREFIX(1)) dut_a (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .data_out(data_a), .brk_out(brk_a), .ext_out(ext_a),
    .empty(empty_a), .level(lvl_a), .overflow(ovf_a), .err(err_a));

  xps2_rx_fifo #(.FIFO_DEPTH_W(DW), .SYNC_STAGES(SYNC),
                 .TIMEOUT_CYC(TMO), .FILTER_PREFIX(0)) dut_b (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .data_out(data_b), .brk_out(brk_b), .ext_out(ext_b),
    .empty(empty_b), .level(lvl_b), .overflow(ovf_b), .err(err_b));

  int checks = 0;
  int errors = 0;
  int err_seen_a = 0;
  int err_seen_b = 0;
  int exp_err = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  bit pend_brk = 0, pend_ext = 0, ovf_ma = 0, ovf_mb = 0;

  always @(posedge clk) begin
    if (err_a === 1'b1) err_seen_a++;
    if (err_b === 1'b1) err_seen_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 10'd0;
    hb = (qb.size() != 0) ? qb[0] : 10'd0;
    chk({tag, ".lvlA"}, 32'(lvl_a), 32'(qa.size()));
    chk({tag, ".emptyA"}, 32'(empty_a), 32'(qa.size() == 0));
    chk({tag, ".headA"}, {21'd0, ext_a, brk_a, data_a}, {22'd0, ha});
    chk({tag, ".ovfA"}, 32'(ovf_a), 32'(ovf_ma));
    chk({tag, ".lvlB"}, 32'(lvl_b), 32'(qb.size()));
    chk({tag, ".emptyB"}, 32'(empty_b), 32'(qb.size() == 0));
    chk({tag, ".headB"}, {21'd0, ext_b, brk_b, data_b}, {22'd0, hb});
    chk({tag, ".ovfB"}, 32'(ovf_b), 32'(ovf_mb));
    chk({tag, ".errA"}, err_seen_a, exp_err);
    chk({tag, ".errB"}, err_seen_b, exp_err);
  endtask

  task automatic model_pop();
    if (qa.size() != 0) qa.delete(0);
    if (qb.size() != 0) qb.delete(0);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok,
                             input bit popped);
    if (popped) model_pop();
    if (!ok) begin
      exp_err++;
      pend_brk = 0;
      pend_ext = 0;
    end else begin
      if (b == 8'hF0) pend_brk = 1;
      else if (b == 8'hE0) pend_ext = 1;
      else begin
        if (qa.size() < DEPTH) qa.push_back({pend_ext, pend_brk, b});
        else ovf_ma = 1;
        pend_brk = 0;
        pend_ext = 0;
      end
      if (qb.size() < DEPTH) qb.push_back({2'b00, b});
      else ovf_mb = 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits,
                            input bit pop_at_push);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (SYNC) @(posedge clk);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par = 0,
                       input bit bad_stop = 0);
    send_frame(b, bad_par, bad_stop, 11, 0);
    model_frame(b, !(bad_par || bad_stop), 0);
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    model_pop();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (qa.size() != 0 || qb.size() != 0) begin
        check_all(tag);
        pop_one();
      end
    end
    check_all({tag, ".done"});
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    pend_brk = 0;
    pend_ext = 0;
    ovf_ma = 0;
    ovf_mb = 0;
    @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int sel, np;

    do_reset();
    check_all("reset");
    chk("reset.err", 32'(err_a), 32'd0);

    frame(8'h79);
    frame(8'hF0);
    frame(8'h79);
    check_all("brk_seq");
    chk("brk_seq.lvl2", 32'(lvl_a), 32'd2);
    pop_one();
    chk("brk_seq.second", {22'd0, ext_a, brk_a, data_a}, {22'd0, 10'h179});
    check_all("brk_seq.pop");
    drain("brk_drain");

    frame(8'h69, 1, 0);
    check_all("bad_parity");
    frame(8'h69);
    check_all("parity_recover");
    frame(8'h5A, 0, 1);
    check_all("bad_stop");

    send_frame(8'h74, 0, 0, 5, 0);
    repeat (TMO + 10) @(negedge clk);
    exp_err++;
    pend_brk = 0;
    pend_ext = 0;
    check_all("timeout");
    frame(8'h74);
    check_all("timeout_recover");
    drain("tmo_drain");

    frame(8'h69);
    frame(8'h74);
    frame(8'h5A);
    frame(8'h7B);
    check_all("full");
    frame(8'h75);
    frame(8'h7D);
    check_all("overflow");
    chk("overflow.lvl", 32'(lvl_a), 32'd4);
    chk("overflow.flag", 32'(ovf_a), 32'd1);
    chk("overflow.head", 32'(data_a), 32'h69);
    drain("ovf_drain");

    do_reset();
    frame(8'h69);
    frame(8'h74);
    frame(8'h5A);
    frame(8'h7B);
    send_frame(8'h5A, 0, 0, 11, 1);
    model_frame(8'h5A, 1, 1);
    check_all("push_pop_full");
    chk("push_pop_full.lvl", 32'(lvl_a), 32'd4);
    chk("push_pop_full.ovf", 32'(ovf_a), 32'd0);
    repeat (3) pop_one();
    chk("push_pop_full.last", 32'(data_a), 32'h5A);
    drain("ppf_drain");

    do_reset();
    frame(8'hE0);
    frame(8'h5A);
    check_all("raw_mode");
    send_frame(8'h33, 0, 0, 3, 0);
    do_reset();
    check_all("midframe_rst");
    frame(8'h75);
    check_all("after_rst");
    drain("rst_drain");

    for (int it = 0; it < 30; it++) begin
      sel = int'($urandom_range(0, 9));
      rb = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 19));
      frame(rb, sel == 0, sel == 1);
      check_all("rand_frame");
      np = int'($urandom_range(0, 2));
      for (int p = 0; p < np; p++) pop_one();
      check_all("rand_pop");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
